// File: rtl/seg_pkg.sv
// Shared definitions for the binary-to-BCD converter and the seven-segment path:
// FSM state encoding and the special BCD digit codes.
package seg_pkg;

   // Converter FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Non-decimal code the display decoder renders as a blank digit
   localparam logic [3:0] BCD_BLANK = 4'hF;
   // Digit value used to saturate the display on overflow
   localparam logic [3:0] BCD_NINE  = 4'h9;
   // Digits at or above this value get +3 before each shift
   localparam logic [3:0] ADD3_MIN  = 4'd5;

endpackage : seg_pkg

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle between the measurement logic (master) and the
// binary-to-BCD converter (slave).
interface bin_to_bcd_seq_if #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
);
   logic                  i_valid;
   logic                  o_ready;
   logic [BIN_W-1:0]      i_bin;
   logic [4*DIGITS-1:0]   o_bcd;
   logic                  o_valid;
   logic                  o_overflow;
   logic                  o_busy;

   modport master (
      output i_valid, i_bin,
      input  o_ready, o_bcd, o_valid, o_overflow, o_busy
   );

   modport slave (
      input  i_valid, i_bin,
      output o_ready, o_bcd, o_valid, o_overflow, o_busy
   );
endinterface : bin_to_bcd_seq_if

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Single-digit correction step of the shift-and-add-3 algorithm:
// a digit of 5 or more gets +3 so the following left shift carries correctly.
module bcd_add3
   import seg_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   assign o_digit = (i_digit >= ADD3_MIN) ? (i_digit + 4'd3) : i_digit;

endmodule : bcd_add3

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-and-add-3).
// A word is accepted in IDLE, shifted through BIN_W SHIFT cycles, and the packed
// result (ones digit in [3:0]) is written once at the last shift edge and held.
// Optional build macro BIN_TO_BCD_BLANK_EN: leading zero digits of a non-overflow
// result are replaced by the blank code so the display suppresses them.
module bin_to_bcd_seq
   import seg_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   bin_to_bcd_seq_if.slave  bus
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   state_e             state_q, state_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [BCD_W-1:0]   work_q, work_d;
   logic               ovf_q, ovf_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               valid_q, valid_d;
   logic               ovf_out_q, ovf_out_d;

   logic [BCD_W-1:0]   corr;
   logic [BCD_W-1:0]   shifted;
   logic [BIN_W-1:0]   bin_shifted;
   logic               carry_out;
   logic               ovf_final;
   logic [BCD_W-1:0]   blanked;
   logic [BCD_W-1:0]   result;

   // One correction unit per work digit; all digits are corrected before the shift
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
         bcd_add3 u_add3 (
            .i_digit (work_q[4*gi +: 4]),
            .o_digit (corr[4*gi +: 4])
         );
      end
   endgenerate

   // Whole {bcd,bin} register moves left one place; the bit leaving the top digit
   // means the value no longer fits in DIGITS decimal digits
   assign {carry_out, shifted, bin_shifted} = {corr, bin_q, 1'b0};
   assign ovf_final = ovf_q | carry_out;

`ifdef BIN_TO_BCD_BLANK_EN
   // Blank zero digits from the top down, stopping at the first non-zero digit;
   // digit 0 is never blanked so a value of zero still shows a single '0'
   always_comb begin
      logic lead;
      blanked = shifted;
      lead    = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (lead && (shifted[4*i +: 4] == 4'd0)) begin
            blanked[4*i +: 4] = BCD_BLANK;
         end else begin
            lead = 1'b0;
         end
      end
   end
`else
   assign blanked = shifted;
`endif

   // Overflow saturates to all nines and bypasses blanking
   assign result = ovf_final ? {DIGITS{BCD_NINE}} : blanked;

   // Next-state logic: FSM, bit counter, work registers and held outputs
   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      work_d    = work_q;
      ovf_d     = ovf_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      ovf_out_d = ovf_out_q;
      valid_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // o_ready is high in IDLE, so i_valid alone marks the accept edge
            if (bus.i_valid) begin
               bin_d   = bus.i_bin;
               work_d  = '0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            bin_d  = bin_shifted;
            work_d = shifted;
            ovf_d  = ovf_final;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               bcd_d     = result;
               ovf_out_d = ovf_final;
               valid_d   = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any conversion in flight
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         bin_q     <= '0;
         work_q    <= '0;
         ovf_q     <= 1'b0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         valid_q   <= 1'b0;
         ovf_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         work_q    <= work_d;
         ovf_q     <= ovf_d;
         cnt_q     <= cnt_d;
         bcd_q     <= bcd_d;
         valid_q   <= valid_d;
         ovf_out_q <= ovf_out_d;
      end
   end

   assign bus.o_ready    = (state_q == ST_IDLE);
   assign bus.o_busy     = (state_q != ST_IDLE);
   assign bus.o_bcd      = bcd_q;
   assign bus.o_valid    = valid_q;
   assign bus.o_overflow = ovf_out_q;

endmodule : bin_to_bcd_seq

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 3-digit instance for the main function and
// a 2-digit instance for overflow saturation. Expected values follow the build
// macro BIN_TO_BCD_BLANK_EN.
module tb_bin_to_bcd_seq;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) b3 ();
   bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(2)) b2 ();

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut3 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (b3.slave)
   );

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (b2.slave)
   );

   // Reference for the 3-digit instance: decimal digits by division, then blanking
   function automatic logic [11:0] ref3(input int v);
      logic [3:0] h, t, o;
      h = 4'(v / 100);
      t = 4'((v / 10) % 10);
      o = 4'(v % 10);
`ifdef BIN_TO_BCD_BLANK_EN
      if (h == 4'd0) begin
         h = 4'hF;
         if (t == 4'd0) t = 4'hF;
      end
`endif
      return {h, t, o};
   endfunction

   // Drive one word into the 3-digit DUT and measure latency and pulse width
   task automatic conv3(input logic [7:0] v, output int lat, output logic [11:0] bcd,
                        output logic ovf, output int width);
      @(negedge clk); b3.i_valid = 1'b1; b3.i_bin = v;
      @(negedge clk); b3.i_valid = 1'b0; b3.i_bin = 8'hA5;
      lat = 0;
      while (b3.o_valid !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
      bcd = b3.o_bcd; ovf = b3.o_overflow; width = 0;
      while (b3.o_valid === 1'b1 && width < 30) begin width++; @(negedge clk); end
      $display("conv3 v=%0d bcd=%h ovf=%b lat=%0d width=%0d", v, bcd, ovf, lat, width);
   endtask

   task automatic conv2(input logic [7:0] v, output int lat, output logic [7:0] bcd,
                        output logic ovf, output int width);
      @(negedge clk); b2.i_valid = 1'b1; b2.i_bin = v;
      @(negedge clk); b2.i_valid = 1'b0; b2.i_bin = 8'h5A;
      lat = 0;
      while (b2.o_valid !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
      bcd = b2.o_bcd; ovf = b2.o_overflow; width = 0;
      while (b2.o_valid === 1'b1 && width < 30) begin width++; @(negedge clk); end
      $display("conv2 v=%0d bcd=%h ovf=%b lat=%0d width=%0d", v, bcd, ovf, lat, width);
   endtask

   task automatic test_reset();
      b3.i_valid = 1'b1; b3.i_bin = 8'd9;
      b2.i_valid = 1'b0; b2.i_bin = 8'd0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      $display("reset: bcd=%h valid=%b ovf=%b busy=%b ready=%b",
               b3.o_bcd, b3.o_valid, b3.o_overflow, b3.o_busy, b3.o_ready);
      n_total++; if (b3.o_bcd !== 12'h000) $display("FAIL reset_bcd got=%h exp=000", b3.o_bcd); else n_pass++;
      n_total++; if (b3.o_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", b3.o_valid); else n_pass++;
      n_total++; if (b3.o_overflow !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", b3.o_overflow); else n_pass++;
      n_total++; if (b3.o_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", b3.o_busy); else n_pass++;
      n_total++; if (b3.o_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", b3.o_ready); else n_pass++;
      n_total++; if (b2.o_bcd !== 8'h00) $display("FAIL reset_bcd2 got=%h exp=00", b2.o_bcd); else n_pass++;
      b3.i_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int lat, width; logic [11:0] bcd; logic ovf;
      conv3(8'd255, lat, bcd, ovf, width);
      n_total++; if (lat !== 8) $display("FAIL basic_latency got=%0d exp=8", lat); else n_pass++;
      n_total++; if (bcd !== 12'h255) $display("FAIL basic_bcd got=%h exp=255", bcd); else n_pass++;
      n_total++; if (ovf !== 1'b0) $display("FAIL basic_ovf got=%b exp=0", ovf); else n_pass++;
      n_total++; if (width !== 1) $display("FAIL basic_pulse got=%0d exp=1", width); else n_pass++;
      n_total++; if (b3.o_bcd !== 12'h255) $display("FAIL basic_hold got=%h exp=255", b3.o_bcd); else n_pass++;
   endtask

   task automatic test_small();
      int lat, width; logic [11:0] bcd; logic ovf;
      logic [11:0] exp7, exp0;
`ifdef BIN_TO_BCD_BLANK_EN
      exp7 = 12'hFF7; exp0 = 12'hFF0;
`else
      exp7 = 12'h007; exp0 = 12'h000;
`endif
      conv3(8'd7, lat, bcd, ovf, width);
      n_total++; if (bcd !== exp7) $display("FAIL small7_bcd got=%h exp=%h", bcd, exp7); else n_pass++;
      conv3(8'd0, lat, bcd, ovf, width);
      n_total++; if (bcd !== exp0) $display("FAIL small0_bcd got=%h exp=%h", bcd, exp0); else n_pass++;
      n_total++; if (ovf !== 1'b0) $display("FAIL small0_ovf got=%b exp=0", ovf); else n_pass++;
   endtask

   task automatic test_overflow();
      int lat, width; logic [7:0] bcd; logic ovf;
      conv2(8'd100, lat, bcd, ovf, width);
      n_total++; if (lat !== 8) $display("FAIL ovf100_latency got=%0d exp=8", lat); else n_pass++;
      n_total++; if (bcd !== 8'h99) $display("FAIL ovf100_bcd got=%h exp=99", bcd); else n_pass++;
      n_total++; if (ovf !== 1'b1) $display("FAIL ovf100_flag got=%b exp=1", ovf); else n_pass++;
      repeat (3) @(negedge clk);
      n_total++; if (b2.o_overflow !== 1'b1) $display("FAIL ovf100_held got=%b exp=1", b2.o_overflow); else n_pass++;
      conv2(8'd42, lat, bcd, ovf, width);
      n_total++; if (bcd !== 8'h42) $display("FAIL ovf42_bcd got=%h exp=42", bcd); else n_pass++;
      n_total++; if (ovf !== 1'b0) $display("FAIL ovf42_flag got=%b exp=0", ovf); else n_pass++;
      conv2(8'd99, lat, bcd, ovf, width);
      n_total++; if (bcd !== 8'h99) $display("FAIL ovf99_bcd got=%h exp=99", bcd); else n_pass++;
      n_total++; if (ovf !== 1'b0) $display("FAIL ovf99_flag got=%b exp=0", ovf); else n_pass++;
      conv2(8'd255, lat, bcd, ovf, width);
      n_total++; if (bcd !== 8'h99) $display("FAIL ovf255_bcd got=%h exp=99", bcd); else n_pass++;
      n_total++; if (ovf !== 1'b1) $display("FAIL ovf255_flag got=%b exp=1", ovf); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0]  vals [3];
      logic [11:0] exps [3];
      int          acc_cyc [3];
      int          pul_cyc [3];
      logic [11:0] pul_val [3];
      int nacc, npul, not_ready;
      vals = '{8'd1, 8'd2, 8'd3};
`ifdef BIN_TO_BCD_BLANK_EN
      exps = '{12'hFF1, 12'hFF2, 12'hFF3};
`else
      exps = '{12'h001, 12'h002, 12'h003};
`endif
      nacc = 0; npul = 0; not_ready = 0;
      for (int cyc = 0; cyc < 36; cyc++) begin
         @(negedge clk);
         if (b3.o_valid === 1'b1 && npul < 3) begin
            pul_cyc[npul] = cyc; pul_val[npul] = b3.o_bcd; npul++;
         end
         if (b3.o_ready === 1'b1) begin
            if (nacc < 3) begin
               b3.i_valid = 1'b1; b3.i_bin = vals[nacc];
               acc_cyc[nacc] = cyc; nacc++;
            end else begin
               b3.i_valid = 1'b0;
            end
         end else begin
            not_ready++;
            b3.i_bin = 8'hEE;
         end
      end
      b3.i_valid = 1'b0;
      $display("b2b: accepts=%0d pulses=%0d not_ready=%0d", nacc, npul, not_ready);
      n_total++; if (npul !== 3) $display("FAIL b2b_pulses got=%0d exp=3", npul); else n_pass++;
      n_total++; if (not_ready !== 27) $display("FAIL b2b_not_ready got=%0d exp=27", not_ready); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         if (i < npul) begin
            $display("b2b pulse %0d at cyc %0d bcd=%h", i, pul_cyc[i], pul_val[i]);
            n_total++; if (pul_val[i] !== exps[i]) $display("FAIL b2b_val%0d got=%h exp=%h", i, pul_val[i], exps[i]); else n_pass++;
            n_total++; if (pul_cyc[i] !== 10*i + 9) $display("FAIL b2b_pulse_cyc%0d got=%0d exp=%0d", i, pul_cyc[i], 10*i + 9); else n_pass++;
         end
         if (i < nacc) begin
            n_total++; if (acc_cyc[i] !== 10*i) $display("FAIL b2b_accept_cyc%0d got=%0d exp=%0d", i, acc_cyc[i], 10*i); else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      @(negedge clk); b3.i_valid = 1'b1; b3.i_bin = 8'd255;
      @(negedge clk); b3.i_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset_mid: bcd=%h valid=%b ready=%b", b3.o_bcd, b3.o_valid, b3.o_ready);
      n_total++; if (b3.o_bcd !== 12'h000) $display("FAIL rstmid_bcd got=%h exp=000", b3.o_bcd); else n_pass++;
      n_total++; if (b3.o_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", b3.o_valid); else n_pass++;
      n_total++; if (b3.o_ready !== 1'b1) $display("FAIL rstmid_ready got=%b exp=1", b3.o_ready); else n_pass++;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (b3.o_valid === 1'b1) pulses++;
      end
      n_total++; if (pulses !== 0) $display("FAIL rstmid_no_pulse got=%0d exp=0", pulses); else n_pass++;
      n_total++; if (b3.o_bcd !== 12'h000) $display("FAIL rstmid_held got=%h exp=000", b3.o_bcd); else n_pass++;
   endtask

   task automatic test_sweep();
      int lat, width; logic [11:0] bcd, exp; logic ovf;
      for (int v = 0; v < 256; v++) begin
         conv3(8'(v), lat, bcd, ovf, width);
         exp = ref3(v);
         n_total++; if (bcd !== exp) $display("FAIL sweep_bcd v=%0d got=%h exp=%h", v, bcd, exp); else n_pass++;
         n_total++; if (width !== 1) $display("FAIL sweep_pulse v=%0d got=%0d exp=1", v, width); else n_pass++;
         n_total++; if (lat !== 8) $display("FAIL sweep_latency v=%0d got=%0d exp=8", v, lat); else n_pass++;
      end
   endtask

   initial begin
      b3.i_valid = 1'b0; b3.i_bin = '0;
      b2.i_valid = 1'b0; b2.i_bin = '0;
      test_reset();
      test_basic();
      test_small();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      test_sweep();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_bin_to_bcd_seq
